axi4_mem_bridge: RTL and testbench

Upstream master for `AXI4_Ram` in the AXI five-stage build. It arbitrates between the core's instruction-fetch port and data-memory port, then drives the simplified AXI4 channel set that the RAM exposes (AW/AR/W with ready, B valid-only, R data-only). Each read or write is returned to the core as a one-cycle response pulse. Only one transaction is outstanding at a time.

---
 rtl/mem_bridge_pkg.sv | 23 ++
 rtl/mem_bridge_arb.sv | 60 ++++++
 rtl/axi4_mem_bridge.sv | 172 +++++++++++++++++
 tb/tb_axi4_mem_bridge.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bridge_pkg.sv
// mem_bridge_pkg: shared types and widths for the axi4_mem_bridge slice.
// Holds the bridge FSM encoding, the request source id and the AXI widths
// used by the RAM side.
package mem_bridge_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 64;
    localparam int AXI_STRB_W = AXI_DATA_W / 8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_AR   = 3'd1,
        ST_R    = 3'd2,
        ST_AW_W = 3'd3,
        ST_B    = 3'd4
    } state_e;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_DM = 1'b1
    } src_e;

endpackage

// File: rtl/mem_bridge_arb.sv
// mem_bridge_arb: fixed-priority selection between the fetch and data ports,
// plus the request latch that holds the accepted transaction while the bridge
// FSM works through the AXI channels. The data port always wins.
module mem_bridge_arb
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  idle,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    input  logic [DATA_W/8-1:0]   dm_wstrb,
    output logic                  if_ready,
    output logic                  dm_ready,
    output logic                  accept,
    output logic                  req_src,
    output logic                  req_we,
    output logic [ADDR_W-1:0]     req_addr,
    output logic [DATA_W-1:0]     req_wdata,
    output logic [DATA_W/8-1:0]   req_wstrb
);

    // Readys are gated by reset so they read 0 while the bridge is held in reset.
    always_comb begin
        dm_ready = reset & idle & dm_req;
        if_ready = reset & idle & if_req & ~dm_req;
        accept   = dm_ready | if_ready;
    end

    // Capture the winning request; fetches are always reads with no strobes.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_src   <= SRC_IF;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
            req_wstrb <= '0;
        end else if (dm_ready) begin
            req_src   <= SRC_DM;
            req_we    <= dm_we;
            req_addr  <= dm_addr;
            req_wdata <= dm_wdata;
            req_wstrb <= dm_wstrb;
        end else if (if_ready) begin
            req_src   <= SRC_IF;
            req_we    <= 1'b0;
            req_addr  <= if_addr;
            req_wdata <= '0;
            req_wstrb <= '0;
        end
    end

endmodule

// File: rtl/axi4_mem_bridge.sv
// axi4_mem_bridge: single-outstanding AXI4 master bridging the core's fetch
// and data ports onto the simplified AXI4_Ram channel set. Responses return
// as one-cycle pulses with held data.
// Optional build macro: MEM_BRIDGE_PERF_EN adds fetch/data/stall counters.
module axi4_mem_bridge
    import mem_bridge_pkg::*;
#(
    parameter int ADDR_W = AXI_ADDR_W,
    parameter int DATA_W = AXI_DATA_W,
    parameter int INST_W = AXI_DATA_W / 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  io_if_req,
    input  logic [ADDR_W-1:0]     io_if_addr,
    output logic                  io_if_ready,
    output logic                  io_if_resp,
    output logic [INST_W-1:0]     io_if_rdata,
    input  logic                  io_dm_req,
    input  logic                  io_dm_we,
    input  logic [ADDR_W-1:0]     io_dm_addr,
    input  logic [DATA_W-1:0]     io_dm_wdata,
    input  logic [DATA_W/8-1:0]   io_dm_wstrb,
    output logic                  io_dm_ready,
    output logic                  io_dm_resp,
    output logic [DATA_W-1:0]     io_dm_rdata,
    output logic [ADDR_W-1:0]     io_awaddr,
    output logic                  io_awvalid,
    input  logic                  io_awready,
    output logic [ADDR_W-1:0]     io_araddr,
    output logic                  io_arvalid,
    input  logic                  io_arready,
    output logic [DATA_W-1:0]     io_wdata,
    output logic [DATA_W/8-1:0]   io_wstrb,
    output logic                  io_wvalid,
    input  logic                  io_wready,
    input  logic [DATA_W-1:0]     io_rdata,
    input  logic                  io_bvalid
`ifdef MEM_BRIDGE_PERF_EN
    ,
    output logic [31:0]           io_perf_if_cnt,
    output logic [31:0]           io_perf_dm_cnt,
    output logic [31:0]           io_perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(7);

    state_e                state;
    state_e                nxt;
    logic                  accept;
    logic                  acc_write;
    logic                  req_src;
    logic                  req_we;
    logic [ADDR_W-1:0]     req_addr;
    logic [DATA_W-1:0]     req_wdata;
    logic [DATA_W/8-1:0]   req_wstrb;
    logic                  arvalid_q;
    logic                  awvalid_q;
    logic                  wvalid_q;

    mem_bridge_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .clock     (clock),
        .reset     (reset),
        .idle      (state == ST_IDLE),
        .if_req    (io_if_req),
        .if_addr   (io_if_addr),
        .dm_req    (io_dm_req),
        .dm_we     (io_dm_we),
        .dm_addr   (io_dm_addr),
        .dm_wdata  (io_dm_wdata),
        .dm_wstrb  (io_dm_wstrb),
        .if_ready  (io_if_ready),
        .dm_ready  (io_dm_ready),
        .accept    (accept),
        .req_src   (req_src),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb)
    );

    assign acc_write = io_dm_ready & io_dm_we;

    // Addresses and write payload come straight from the request latch, so no
    // AXI input can reach an AXI output combinationally.
    assign io_araddr  = req_addr & ALIGN_MASK;
    assign io_awaddr  = req_addr & ALIGN_MASK;
    assign io_wdata   = req_wdata;
    assign io_wstrb   = req_wstrb;
    assign io_arvalid = arvalid_q;
    assign io_awvalid = awvalid_q;
    assign io_wvalid  = wvalid_q;

    // Next-state decode; AW_W waits until both channels have handshaken.
    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE: if (accept)     nxt = acc_write ? ST_AW_W : ST_AR;
            ST_AR:   if (io_arready) nxt = ST_R;
            ST_R:                    nxt = ST_IDLE;
            ST_AW_W: if ((~awvalid_q | io_awready) & (~wvalid_q | io_wready)) nxt = ST_B;
            ST_B:    if (io_bvalid)  nxt = ST_IDLE;
            default:                 nxt = ST_IDLE;
        endcase
    end

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= nxt;
    end

    // AXI valids rise on acceptance and each drops after its own handshake.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            arvalid_q <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
        end else if (accept) begin
            arvalid_q <= ~acc_write;
            awvalid_q <= acc_write;
            wvalid_q  <= acc_write;
        end else begin
            if (arvalid_q & io_arready) arvalid_q <= 1'b0;
            if (awvalid_q & io_awready) awvalid_q <= 1'b0;
            if (wvalid_q & io_wready)   wvalid_q  <= 1'b0;
        end
    end

    // Response pulses and held response data for the requesting port.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_if_resp  <= 1'b0;
            io_dm_resp  <= 1'b0;
            io_if_rdata <= '0;
            io_dm_rdata <= '0;
        end else begin
            io_if_resp <= 1'b0;
            io_dm_resp <= 1'b0;
            if (state == ST_R) begin
                if (req_src == SRC_IF) begin
                    io_if_resp  <= 1'b1;
                    io_if_rdata <= req_addr[2] ? io_rdata[DATA_W-1:INST_W] : io_rdata[INST_W-1:0];
                end else begin
                    io_dm_resp  <= 1'b1;
                    io_dm_rdata <= io_rdata;
                end
            end
            if ((state == ST_B) && io_bvalid && req_we) io_dm_resp <= 1'b1;
        end
    end

`ifdef MEM_BRIDGE_PERF_EN
    // Wrapping counters of accepted requests and starved fetch cycles.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            io_perf_if_cnt    <= '0;
            io_perf_dm_cnt    <= '0;
            io_perf_stall_cnt <= '0;
        end else begin
            if (io_if_ready)               io_perf_if_cnt    <= io_perf_if_cnt + 32'd1;
            if (io_dm_ready)               io_perf_dm_cnt    <= io_perf_dm_cnt + 32'd1;
            if (io_if_req & ~io_if_ready)  io_perf_stall_cnt <= io_perf_stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_axi4_mem_bridge.sv
// tb_axi4_mem_bridge: directed bench for axi4_mem_bridge. The AXI RAM side is
// driven by hand, cycle by cycle, with hand-computed expectations.
module tb_axi4_mem_bridge;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_if_req;
    logic [31:0] io_if_addr;
    logic        io_if_ready;
    logic        io_if_resp;
    logic [31:0] io_if_rdata;
    logic        io_dm_req;
    logic        io_dm_we;
    logic [31:0] io_dm_addr;
    logic [63:0] io_dm_wdata;
    logic [7:0]  io_dm_wstrb;
    logic        io_dm_ready;
    logic        io_dm_resp;
    logic [63:0] io_dm_rdata;
    logic [31:0] io_awaddr;
    logic        io_awvalid;
    logic        io_awready;
    logic [31:0] io_araddr;
    logic        io_arvalid;
    logic        io_arready;
    logic [63:0] io_wdata;
    logic [7:0]  io_wstrb;
    logic        io_wvalid;
    logic        io_wready;
    logic [63:0] io_rdata;
    logic        io_bvalid;
`ifdef MEM_BRIDGE_PERF_EN
    logic [31:0] io_perf_if_cnt;
    logic [31:0] io_perf_dm_cnt;
    logic [31:0] io_perf_stall_cnt;
    int          exp_if;
    int          exp_dm;
    int          exp_stall;
`endif

    int checks = 0;
    int errors = 0;

    axi4_mem_bridge dut (
        .clock       (clock),
        .reset       (reset),
        .io_if_req   (io_if_req),
        .io_if_addr  (io_if_addr),
        .io_if_ready (io_if_ready),
        .io_if_resp  (io_if_resp),
        .io_if_rdata (io_if_rdata),
        .io_dm_req   (io_dm_req),
        .io_dm_we    (io_dm_we),
        .io_dm_addr  (io_dm_addr),
        .io_dm_wdata (io_dm_wdata),
        .io_dm_wstrb (io_dm_wstrb),
        .io_dm_ready (io_dm_ready),
        .io_dm_resp  (io_dm_resp),
        .io_dm_rdata (io_dm_rdata),
        .io_awaddr   (io_awaddr),
        .io_awvalid  (io_awvalid),
        .io_awready  (io_awready),
        .io_araddr   (io_araddr),
        .io_arvalid  (io_arvalid),
        .io_arready  (io_arready),
        .io_wdata    (io_wdata),
        .io_wstrb    (io_wstrb),
        .io_wvalid   (io_wvalid),
        .io_wready   (io_wready),
        .io_rdata    (io_rdata),
        .io_bvalid   (io_bvalid)
`ifdef MEM_BRIDGE_PERF_EN
        ,
        .io_perf_if_cnt    (io_perf_if_cnt),
        .io_perf_dm_cnt    (io_perf_dm_cnt),
        .io_perf_stall_cnt (io_perf_stall_cnt)
`endif
    );

    always #5 clock = ~clock;

`ifdef MEM_BRIDGE_PERF_EN
    // Expected counter values from observed handshakes at each clock edge.
    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            exp_if = 0;
            exp_dm = 0;
            exp_stall = 0;
        end else begin
            if (io_if_req && io_if_ready) exp_if = exp_if + 1;
            if (io_dm_req && io_dm_ready) exp_dm = exp_dm + 1;
            if (io_if_req && !io_if_ready) exp_stall = exp_stall + 1;
        end
    end
`endif

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0;
        io_if_req = 1'b1; io_if_addr = 32'h8000_0000;
        io_dm_req = 1'b1; io_dm_we = 1'b0; io_dm_addr = 32'h8000_0000;
        io_dm_wdata = '0; io_dm_wstrb = '0;
        io_awready = 1'b0; io_arready = 1'b0; io_wready = 1'b0;
        io_rdata = '0; io_bvalid = 1'b0;

        // Reset state, with both requests asserted.
        #3;
        check("rst_if_ready", io_if_ready, 0);
        check("rst_dm_ready", io_dm_ready, 0);
        check("rst_arvalid", io_arvalid, 0);
        check("rst_awvalid", io_awvalid, 0);
        check("rst_wvalid", io_wvalid, 0);
        check("rst_if_resp", io_if_resp, 0);
        check("rst_dm_resp", io_dm_resp, 0);
        check("rst_if_rdata", io_if_rdata, 0);
        check("rst_dm_rdata", io_dm_rdata, 0);
        io_if_req = 1'b0; io_dm_req = 1'b0;
        cycle();
        cycle();
        reset = 1'b1;

        // Fetch read of the upper word.
        cycle();
        io_if_req = 1'b1; io_if_addr = 32'h8000_0004;
        settle();
        check("f_if_ready", io_if_ready, 1);
        check("f_dm_ready", io_dm_ready, 0);
        cycle();
        io_if_req = 1'b0; io_arready = 1'b1;
        settle();
        check("f_arvalid", io_arvalid, 1);
        check("f_araddr", io_araddr, 64'h8000_0000);
        check("f_awvalid", io_awvalid, 0);
        check("f_if_ready_busy", io_if_ready, 0);
        cycle();
        io_arready = 1'b0; io_rdata = 64'h1111_2222_3333_4444;
        settle();
        check("f_arvalid_drop", io_arvalid, 0);
        check("f_if_resp_early", io_if_resp, 0);
        cycle();
        io_rdata = 64'h0;
        settle();
        check("f_if_resp", io_if_resp, 1);
        check("f_if_rdata", io_if_rdata, 64'h1111_2222);
        check("f_dm_resp", io_dm_resp, 0);
        cycle();
        settle();
        check("f_if_resp_pulse", io_if_resp, 0);
        check("f_if_rdata_hold", io_if_rdata, 64'h1111_2222);

        // Simultaneous requests: data read wins, fetch follows.
        io_if_req = 1'b1; io_if_addr = 32'h8000_0010;
        io_dm_req = 1'b1; io_dm_we = 1'b0; io_dm_addr = 32'h8000_0008;
        settle();
        check("c_dm_ready", io_dm_ready, 1);
        check("c_if_ready", io_if_ready, 0);
        cycle();
        io_dm_req = 1'b0; io_arready = 1'b1;
        settle();
        check("c_if_ready_ar", io_if_ready, 0);
        check("c_araddr", io_araddr, 64'h8000_0008);
        cycle();
        io_arready = 1'b0; io_rdata = 64'hAAAA_BBBB_CCCC_DDDD;
        settle();
        check("c_if_ready_r", io_if_ready, 0);
        cycle();
        io_rdata = 64'h0;
        settle();
        check("c_dm_resp", io_dm_resp, 1);
        check("c_dm_rdata", io_dm_rdata, 64'hAAAA_BBBB_CCCC_DDDD);
        check("c_if_resp", io_if_resp, 0);
        check("c_if_ready_after", io_if_ready, 1);
        cycle();
        io_if_req = 1'b0; io_arready = 1'b1;
        settle();
        check("c_f_arvalid", io_arvalid, 1);
        check("c_f_araddr", io_araddr, 64'h8000_0010);
        check("c_dm_resp_pulse", io_dm_resp, 0);
        cycle();
        io_arready = 1'b0; io_rdata = 64'h5555_6666_7777_8888;
        settle();
        cycle();
        io_rdata = 64'h0;
        settle();
        check("c_f_if_resp", io_if_resp, 1);
        check("c_f_if_rdata", io_if_rdata, 64'h7777_8888);
        check("c_dm_rdata_hold", io_dm_rdata, 64'hAAAA_BBBB_CCCC_DDDD);

        // Write with skewed AW/W handshakes.
        cycle();
        io_dm_req = 1'b1; io_dm_we = 1'b1; io_dm_addr = 32'h8000_0023;
        io_dm_wdata = 64'hDEAD_BEEF_0123_4567; io_dm_wstrb = 8'h0F;
        settle();
        check("w_dm_ready", io_dm_ready, 1);
        cycle();
        io_dm_req = 1'b0; io_dm_we = 1'b0; io_awready = 1'b1;
        settle();
        check("w_awvalid", io_awvalid, 1);
        check("w_wvalid", io_wvalid, 1);
        check("w_arvalid", io_arvalid, 0);
        check("w_awaddr", io_awaddr, 64'h8000_0020);
        check("w_wdata", io_wdata, 64'hDEAD_BEEF_0123_4567);
        check("w_wstrb", io_wstrb, 64'h0F);
        cycle();
        io_awready = 1'b0;
        settle();
        check("w_awvalid_drop", io_awvalid, 0);
        check("w_wvalid_held", io_wvalid, 1);
        cycle();
        io_wready = 1'b1;
        settle();
        check("w_wvalid_t3", io_wvalid, 1);
        cycle();
        io_wready = 1'b0; io_bvalid = 1'b1;
        settle();
        check("w_wvalid_drop", io_wvalid, 0);
        check("w_dm_resp_early", io_dm_resp, 0);
        cycle();
        io_bvalid = 1'b0;
        settle();
        check("w_dm_resp", io_dm_resp, 1);
        check("w_if_resp", io_if_resp, 0);
        cycle();
        settle();
        check("w_dm_resp_pulse", io_dm_resp, 0);

        // Read with four cycles of arready low.
        io_dm_req = 1'b1; io_dm_we = 1'b0; io_dm_addr = 32'h8000_0104;
        settle();
        check("ws_dm_ready", io_dm_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cycle();
            io_dm_req = 1'b0;
            settle();
            check("ws_arvalid", io_arvalid, 1);
            check("ws_araddr", io_araddr, 64'h8000_0100);
        end
        cycle();
        io_arready = 1'b1;
        settle();
        check("ws_arvalid_t5", io_arvalid, 1);
        cycle();
        io_arready = 1'b0; io_rdata = 64'h0102_0304_0506_0708;
        settle();
        check("ws_dm_resp_t6", io_dm_resp, 0);
        cycle();
        io_rdata = 64'h0;
        settle();
        check("ws_dm_resp_t7", io_dm_resp, 1);
        check("ws_dm_rdata", io_dm_rdata, 64'h0102_0304_0506_0708);

        // Reset asserted while in AW_W.
        cycle();
        io_dm_req = 1'b1; io_dm_we = 1'b1; io_dm_addr = 32'h8000_0040;
        io_dm_wdata = 64'h1; io_dm_wstrb = 8'hFF;
        settle();
        cycle();
        io_dm_req = 1'b0; io_dm_we = 1'b0;
        settle();
        check("ra_awvalid", io_awvalid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("ra_awvalid_rst", io_awvalid, 0);
        check("ra_wvalid_rst", io_wvalid, 0);
        check("ra_arvalid_rst", io_arvalid, 0);
        cycle();
        cycle();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("ra_dm_resp", io_dm_resp, 0);
            check("ra_awvalid_after", io_awvalid, 0);
        end
        io_if_req = 1'b1; io_if_addr = 32'h8000_0044;
        settle();
        check("ra_if_ready", io_if_ready, 1);
        cycle();
        io_if_req = 1'b0; io_arready = 1'b1;
        settle();
        check("ra_araddr", io_araddr, 64'h8000_0040);
        cycle();
        io_arready = 1'b0; io_rdata = 64'hCAFE_F00D_1234_5678;
        settle();
        cycle();
        io_rdata = 64'h0;
        settle();
        check("ra_if_resp", io_if_resp, 1);
        check("ra_if_rdata", io_if_rdata, 64'hCAFE_F00D);
        check("ra_dm_resp_none", io_dm_resp, 0);

`ifdef MEM_BRIDGE_PERF_EN
        cycle();
        settle();
        check("perf_if", io_perf_if_cnt, exp_if);
        check("perf_dm", io_perf_dm_cnt, exp_dm);
        check("perf_stall", io_perf_stall_cnt, exp_stall);
`endif

        cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
